// File: rtl/sw_seq_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sw_seq_feeder
//  Description : Feeds a linear Smith-Waterman PE array. Loads the short read
//                into the PEs (store_S_out), streams the reference through
//                them (init_out), then drains the pipeline before signalling
//                done. Boundary V/F columns are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_seq_feeder #(
    parameter int NUM_PE  = 8,
    parameter int LEN_W   = 10,
    parameter int SCORE_W = 10
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active low
    input  logic               start,
    input  logic [LEN_W-1:0]   read_len,
    input  logic [LEN_W-1:0]   ref_len,
    input  logic               rd_valid,
    output logic               rd_ready,
    input  logic [1:0]         rd_sym,
    input  logic               ref_valid,
    output logic               ref_ready,
    input  logic [1:0]         ref_sym,
    output logic [1:0]         S_out,
    output logic               store_S_out,
    output logic [1:0]         T_out,
    output logic               init_out,
    output logic               stall,
    output logic [SCORE_W-1:0] V_out,
    output logic [SCORE_W-1:0] F_out,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_S   = 2'd1,
        ST_STREAM_T = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] C_MAX_READ = LEN_W'(NUM_PE);
    localparam logic [LEN_W-1:0] C_ONE      = LEN_W'(1);

    state_t             state_q,    state_d;
    logic [LEN_W-1:0]   read_len_q, read_len_d;
    logic [LEN_W-1:0]   ref_len_q,  ref_len_d;
    logic [LEN_W-1:0]   s_cnt_q,    s_cnt_d;
    logic [LEN_W-1:0]   t_cnt_q,    t_cnt_d;
    logic [LEN_W-1:0]   d_cnt_q,    d_cnt_d;
    logic [1:0]         s_q,        s_d;
    logic [1:0]         t_q,        t_d;
    logic               store_s_q,  store_s_d;
    logic               init_q,     init_d;
    logic               stall_q,    stall_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;

    logic               w_rd_fire;
    logic               w_ref_fire;
    logic               w_len_ok;
    logic [LEN_W-1:0]   w_s_cnt_inc;
    logic [LEN_W-1:0]   w_t_cnt_inc;
    logic [LEN_W-1:0]   w_d_cnt_inc;

    // Ready is a pure decode of the registered state, so a transfer can only
    // ever happen in the state that owns the corresponding stream.
    assign rd_ready    = (state_q == ST_LOAD_S);
    assign ref_ready   = (state_q == ST_STREAM_T);
    assign busy        = (state_q != ST_IDLE);
    assign w_rd_fire   = rd_ready  && rd_valid;
    assign w_ref_fire  = ref_ready && ref_valid;
    assign w_len_ok    = (read_len != '0) && (read_len <= C_MAX_READ);
    assign w_s_cnt_inc = s_cnt_q + C_ONE;
    assign w_t_cnt_inc = t_cnt_q + C_ONE;
    assign w_d_cnt_inc = d_cnt_q + C_ONE;

    assign S_out       = s_q;
    assign T_out       = t_q;
    assign store_S_out = store_s_q;
    assign init_out    = init_q;
    assign stall       = stall_q;
    assign done        = done_q;
    assign err         = err_q;
    assign V_out       = '0;
    assign F_out       = '0;

    // Next-state and next-output decision for the feeder FSM.
    always_comb begin
        state_d    = state_q;
        read_len_d = read_len_q;
        ref_len_d  = ref_len_q;
        s_cnt_d    = s_cnt_q;
        t_cnt_d    = t_cnt_q;
        d_cnt_d    = d_cnt_q;
        s_d        = s_q;
        t_d        = t_q;
        store_s_d  = 1'b0;
        init_d     = init_q;
        stall_d    = stall_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                init_d  = 1'b0;
                stall_d = 1'b0;
                s_cnt_d = '0;
                t_cnt_d = '0;
                d_cnt_d = '0;
                if (start) begin
                    if (w_len_ok) begin
                        read_len_d = read_len;
                        ref_len_d  = ref_len;
                        state_d    = ST_LOAD_S;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD_S: begin
                init_d = 1'b0;
                if (w_rd_fire) begin
                    s_d       = rd_sym;
                    store_s_d = 1'b1;
                    stall_d   = 1'b0;
                    s_cnt_d   = w_s_cnt_inc;
                    if (w_s_cnt_inc == read_len_q) begin
                        // An empty reference skips straight to draining.
                        state_d = (ref_len_q == '0) ? ST_DRAIN : ST_STREAM_T;
                    end
                end else begin
                    stall_d = 1'b1;
                end
            end

            ST_STREAM_T: begin
                if (w_ref_fire) begin
                    t_d     = ref_sym;
                    init_d  = 1'b1;
                    stall_d = 1'b0;
                    t_cnt_d = w_t_cnt_inc;
                    if (w_t_cnt_inc == ref_len_q) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    // Array is frozen; T/init keep their last values.
                    stall_d = 1'b1;
                end
            end

            ST_DRAIN: begin
                init_d  = 1'b0;
                stall_d = 1'b0;
                d_cnt_d = w_d_cnt_inc;
                if (w_d_cnt_inc == read_len_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered-output flops; reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            read_len_q <= '0;
            ref_len_q  <= '0;
            s_cnt_q    <= '0;
            t_cnt_q    <= '0;
            d_cnt_q    <= '0;
            s_q        <= 2'b00;
            t_q        <= 2'b00;
            store_s_q  <= 1'b0;
            init_q     <= 1'b0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            read_len_q <= read_len_d;
            ref_len_q  <= ref_len_d;
            s_cnt_q    <= s_cnt_d;
            t_cnt_q    <= t_cnt_d;
            d_cnt_q    <= d_cnt_d;
            s_q        <= s_d;
            t_q        <= t_d;
            store_s_q  <= store_s_d;
            init_q     <= init_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule
`default_nettype wire
